// File: rtl/cmos_cfg_sequencer_if.sv
// ---------------------------------------------------------------------------
// cmos_cfg_sequencer_if
//   Request/response bundle between the camera config sequencer and a
//   byte-level I2C master.
//   master modport (sequencer side):
//     out: i2c_req, i2c_rw, i2c_dev_addr, i2c_reg_addr, i2c_wdata
//     in : i2c_ready, i2c_done, i2c_nack, i2c_rdata
//   slave modport (I2C master side): the reverse directions.
//   A request is accepted on any cycle with i2c_req && i2c_ready; the
//   outcome arrives later as a one-cycle i2c_done with i2c_nack/i2c_rdata.
// ---------------------------------------------------------------------------
interface cmos_cfg_sequencer_if #(
  parameter int REG_ADDR_W = 16,
  parameter int DATA_W     = 8
);
  logic                  i2c_req;
  logic                  i2c_ready;
  logic                  i2c_rw;
  logic [7:0]            i2c_dev_addr;
  logic [REG_ADDR_W-1:0] i2c_reg_addr;
  logic [DATA_W-1:0]     i2c_wdata;
  logic                  i2c_done;
  logic                  i2c_nack;
  logic [DATA_W-1:0]     i2c_rdata;

  modport master (
    output i2c_req, i2c_rw, i2c_dev_addr, i2c_reg_addr, i2c_wdata,
    input  i2c_ready, i2c_done, i2c_nack, i2c_rdata
  );

  modport slave (
    input  i2c_req, i2c_rw, i2c_dev_addr, i2c_reg_addr, i2c_wdata,
    output i2c_ready, i2c_done, i2c_nack, i2c_rdata
  );
endinterface

// File: rtl/cmos_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// cmos_cfg_sequencer
//   Walks a register table and issues one I2C write per entry. Entries with
//   dev_addr == DELAY_DEV wait reg_data milliseconds, dev_addr == END_DEV
//   ends the walk. NACKed writes are retried up to MAX_RETRY times before
//   the walk stops with error and the failing index.
//
//   Optional build macro: CMOS_CFG_VERIFY_EN
//     Each acknowledged write is followed by a read-back of the same
//     register; a NACK or data mismatch on the read burns one retry and
//     re-issues the write. Adds the sticky verify_fail output.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle pulse, starts a walk from index 0 when idle
//   lut_index    table address (LUT is combinational)
//   lut_data     {dev_addr, reg_addr, reg_data} at lut_index
//   bus          I2C request/response bundle (master modport)
//   busy         walk in progress
//   done         sticky, table completed
//   error        sticky, retries exhausted on an entry
//   err_index    index of the failing entry
//   verify_fail  (CMOS_CFG_VERIFY_EN only) sticky, error caused by a
//                read-back data mismatch
// ---------------------------------------------------------------------------
module cmos_cfg_sequencer #(
  parameter int         LUT_DEPTH    = 256,
  parameter int         IDX_W        = 10,
  parameter int         REG_ADDR_W   = 16,
  parameter int         DATA_W       = 8,
  parameter int         TICKS_PER_MS = 50000,
  parameter int         MAX_RETRY    = 3,
  parameter logic [7:0] DELAY_DEV    = 8'hFE,
  parameter logic [7:0] END_DEV      = 8'hFF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic [IDX_W-1:0]             lut_index,
  input  logic [8+REG_ADDR_W+DATA_W-1:0] lut_data,
  cmos_cfg_sequencer_if.master         bus,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [IDX_W-1:0]             err_index
`ifdef CMOS_CFG_VERIFY_EN
  ,
  output logic                         verify_fail
`endif
);

  localparam int TICK_W  = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(LUT_DEPTH - 1);
  localparam logic [TICK_W-1:0]  LAST_TICK = TICK_W'(TICKS_PER_MS - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  typedef struct packed {
    logic [7:0]            dev;
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0]     data;
  } entry_t;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DELAY, S_NEXT, S_FIN, S_ERR
`ifdef CMOS_CFG_VERIFY_EN
    , S_VISSUE, S_VWAIT
`endif
  } state_t;

  state_t              state_q, state_d;
  entry_t              entry_q, entry_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    err_idx_q, err_idx_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [DATA_W-1:0]   ms_q, ms_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                req_q, req_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
`ifdef CMOS_CFG_VERIFY_EN
  logic                rw_q, rw_d;
  logic                vfail_q, vfail_d;
`endif

  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    idx_d     = idx_q;
    err_idx_d = err_idx_q;
    retry_d   = retry_q;
    ms_d      = ms_q;
    tick_d    = tick_q;
    req_d     = req_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
`ifdef CMOS_CFG_VERIFY_EN
    rw_d      = rw_q;
    vfail_d   = vfail_q;
`endif
    case (state_q)
      // start is honoured only here, so a pulse coinciding with FIN/ERR
      // (or arriving mid-walk) is dropped.
      S_IDLE: begin
        if (start) begin
          state_d   = S_FETCH;
          idx_d     = '0;
          err_idx_d = '0;
          retry_d   = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          error_d   = 1'b0;
`ifdef CMOS_CFG_VERIFY_EN
          vfail_d   = 1'b0;
`endif
        end
      end
      // The only cycle the LUT is sampled; the entry register then feeds
      // the bus fields so they stay stable across stalls and retries.
      S_FETCH: begin
        entry_d = lut_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (entry_q.dev == END_DEV) begin
          state_d = S_FIN;
        end else if (entry_q.dev == DELAY_DEV) begin
          state_d = S_DELAY;
          ms_d    = entry_q.data;
          tick_d  = '0;
        end else begin
          state_d = S_ISSUE;
          req_d   = 1'b1;
`ifdef CMOS_CFG_VERIFY_EN
          rw_d    = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        if (bus.i2c_ready) begin
          req_d   = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.i2c_done) begin
          if (!bus.i2c_nack) begin
`ifdef CMOS_CFG_VERIFY_EN
            state_d = S_VISSUE;
            req_d   = 1'b1;
            rw_d    = 1'b1;
`else
            state_d = S_NEXT;
            retry_d = '0;
`endif
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = S_ISSUE;
            req_d   = 1'b1;
          end else begin
            state_d   = S_ERR;
            err_idx_d = idx_q;
          end
        end
      end
`ifdef CMOS_CFG_VERIFY_EN
      S_VISSUE: begin
        if (bus.i2c_ready) begin
          req_d   = 1'b0;
          state_d = S_VWAIT;
        end
      end
      // A bad read-back spends the same retry budget as a NACKed write and
      // restarts the attempt from the write.
      S_VWAIT: begin
        if (bus.i2c_done) begin
          if (!bus.i2c_nack && (bus.i2c_rdata == entry_q.data)) begin
            state_d = S_NEXT;
            retry_d = '0;
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = S_ISSUE;
            req_d   = 1'b1;
            rw_d    = 1'b0;
          end else begin
            state_d   = S_ERR;
            err_idx_d = idx_q;
            vfail_d   = !bus.i2c_nack;
          end
        end
      end
`endif
      // ms_q counts whole milliseconds, tick_q the clocks inside one.
      // A zero count leaves after a single cycle.
      S_DELAY: begin
        if (ms_q == '0) begin
          state_d = S_NEXT;
        end else if (tick_q == LAST_TICK) begin
          tick_d = '0;
          ms_d   = ms_q - DATA_W'(1);
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_NEXT: begin
        retry_d = '0;
        if (idx_q == LAST_IDX) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_FETCH;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      entry_q   <= '0;
      idx_q     <= '0;
      err_idx_q <= '0;
      retry_q   <= '0;
      ms_q      <= '0;
      tick_q    <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef CMOS_CFG_VERIFY_EN
      rw_q      <= 1'b0;
      vfail_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      idx_q     <= idx_d;
      err_idx_q <= err_idx_d;
      retry_q   <= retry_d;
      ms_q      <= ms_d;
      tick_q    <= tick_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
`ifdef CMOS_CFG_VERIFY_EN
      rw_q      <= rw_d;
      vfail_q   <= vfail_d;
`endif
    end
  end

  assign lut_index        = idx_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign err_index        = err_idx_q;
  assign bus.i2c_req      = req_q;
  assign bus.i2c_dev_addr = entry_q.dev;
  assign bus.i2c_reg_addr = entry_q.reg_addr;
  assign bus.i2c_wdata    = entry_q.data;

`ifdef CMOS_CFG_VERIFY_EN
  assign bus.i2c_rw       = rw_q;
  assign verify_fail      = vfail_q;
`else
  // Write-only build: read data has no consumer.
  logic unused_rdata;
  assign bus.i2c_rw       = 1'b0;
  assign unused_rdata     = ^bus.i2c_rdata;
`endif

endmodule

// File: tb/tb_cmos_cfg_sequencer.sv
module tb_cmos_cfg_sequencer;
  localparam int IDX_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [IDX_W-1:0]  lut_index;
  logic [31:0]       lut_data;
  logic              busy, done, error;
  logic [IDX_W-1:0]  err_index;
`ifdef CMOS_CFG_VERIFY_EN
  logic              verify_fail;
`endif
  logic [31:0]       lut_mem [16];

  int checks = 0;
  int failures = 0;

  cmos_cfg_sequencer_if #(.REG_ADDR_W(16), .DATA_W(8)) ifc ();

  cmos_cfg_sequencer #(
    .LUT_DEPTH(8), .IDX_W(IDX_W), .REG_ADDR_W(16), .DATA_W(8),
    .TICKS_PER_MS(10), .MAX_RETRY(3), .DELAY_DEV(8'hFE), .END_DEV(8'hFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .lut_index(lut_index), .lut_data(lut_data), .bus(ifc.master),
    .busy(busy), .done(done), .error(error), .err_index(err_index)
`ifdef CMOS_CFG_VERIFY_EN
    , .verify_fail(verify_fail)
`endif
  );

  always #5 clk = ~clk;
  assign lut_data = lut_mem[lut_index];

  // ---------------- I2C master model and transaction log ----------------
  int          cyc = 0;
  int          acc_cnt = 0;
  int          acc_idx [64];
  logic [7:0]  acc_dev [64];
  logic [15:0] acc_reg [64];
  logic [7:0]  acc_dat [64];
  logic        acc_rw  [64];
  int          acc_cyc [64];
  int          done_log [64];
  int          done_cnt = 0;
  int          nack_idx = -1;
  int          nack_times = 0;
  int          nack_given = 0;
  bit          rd_corrupt = 1'b0;
  int          pend = 0;
  bit          pend_nack;
  logic [7:0]  pend_rdata;
  logic [7:0]  last_w = 8'h00;

  initial begin
    ifc.i2c_done  = 1'b0;
    ifc.i2c_nack  = 1'b0;
    ifc.i2c_rdata = 8'h00;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n && ifc.i2c_req && ifc.i2c_ready && acc_cnt < 64) begin
        acc_idx[acc_cnt] = int'(lut_index);
        acc_dev[acc_cnt] = ifc.i2c_dev_addr;
        acc_reg[acc_cnt] = ifc.i2c_reg_addr;
        acc_dat[acc_cnt] = ifc.i2c_wdata;
        acc_rw[acc_cnt]  = ifc.i2c_rw;
        acc_cyc[acc_cnt] = cyc;
        acc_cnt++;
        pend_nack = 1'b0;
        if (!ifc.i2c_rw) begin
          last_w = ifc.i2c_wdata;
          if (int'(lut_index) == nack_idx && nack_given < nack_times) begin
            pend_nack = 1'b1;
            nack_given++;
          end
        end
        pend_rdata = ifc.i2c_rw ? (rd_corrupt ? 8'hAA : last_w) : 8'h00;
        pend = 2;
      end
      #1;
      ifc.i2c_done = 1'b0;
      ifc.i2c_nack = 1'b0;
      if (!rst_n) pend = 0;
      else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          ifc.i2c_done  = 1'b1;
          ifc.i2c_nack  = pend_nack;
          ifc.i2c_rdata = pend_rdata;
          if (done_cnt < 64) done_log[done_cnt] = cyc + 1;
          done_cnt++;
        end
      end
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  function automatic int wr_cnt(input int idx);
    int n = 0;
    for (int i = 0; i < acc_cnt; i++)
      if (!acc_rw[i] && (idx < 0 || acc_idx[i] == idx)) n++;
    return n;
  endfunction

  function automatic int rd_cnt();
    int n = 0;
    for (int i = 0; i < acc_cnt; i++) if (acc_rw[i]) n++;
    return n;
  endfunction

  task automatic clear_log();
    acc_cnt = 0; done_cnt = 0; nack_given = 0;
  endtask

  task automatic load_basic();
    for (int i = 0; i < 16; i++) lut_mem[i] = {8'hFF, 16'h0000, 8'h00};
    lut_mem[0] = {8'h42, 16'h3008, 8'h82};
    lut_mem[1] = {8'h42, 16'h3103, 8'h03};
    lut_mem[2] = {8'h42, 16'h3017, 8'h7F};
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_end(output bit timed_out);
    int n = 0;
    while (!(done || error) && n < 600) begin
      @(negedge clk);
      n++;
    end
    timed_out = !(done || error);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    ifc.i2c_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({busy, done, error, ifc.i2c_req} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, error, ifc.i2c_req}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (lut_index !== 4'd0 || err_index !== 4'd0) begin
      failures++; $display("FAIL reset_idx got=%0d/%0d exp=0/0", lut_index, err_index); end
    checks++; if (ifc.i2c_rw !== 1'b0) begin
      failures++; $display("FAIL reset_rw got=%b exp=0", ifc.i2c_rw); end
  endtask

  task automatic test_basic();
    bit to;
    bit busy_at_done;
    load_basic(); clear_log();
    pulse_start();
    @(negedge clk);
    checks++; if (ifc.i2c_req !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL basic_fetch req=%b busy=%b exp req=0 busy=1", ifc.i2c_req, busy); end
    @(negedge clk);
    checks++; if (ifc.i2c_req !== 1'b0) begin
      failures++; $display("FAIL basic_decode req=%b exp=0", ifc.i2c_req); end
    @(negedge clk);
    checks++; if (ifc.i2c_req !== 1'b1) begin
      failures++; $display("FAIL basic_latency req=%b exp=1", ifc.i2c_req); end
    wait_end(to);
    busy_at_done = busy;
    checks++; if (to) begin failures++; $display("FAIL basic_timeout"); end
    checks++; if (wr_cnt(-1) !== 3) begin
      failures++; $display("FAIL basic_wr_count got=%0d exp=3", wr_cnt(-1)); end
    for (int i = 0, w = 0; i < acc_cnt; i++) begin
      if (!acc_rw[i]) begin
        checks++;
        if (acc_idx[i] !== w || {acc_dev[i], acc_reg[i], acc_dat[i]} !== lut_mem[w]) begin
          failures++;
          $display("FAIL basic_fields[%0d] got idx=%0d %h_%h_%h exp idx=%0d %h",
                   w, acc_idx[i], acc_dev[i], acc_reg[i], acc_dat[i], w, lut_mem[w]);
        end
        w++;
      end
    end
    checks++; if ({done, error, busy_at_done} !== 3'b100 || lut_index !== 4'd3) begin
      failures++; $display("FAIL basic_end done/err/busy=%b idx=%0d exp=100 idx=3",
                           {done, error, busy_at_done}, lut_index); end
`ifndef CMOS_CFG_VERIFY_EN
    checks++; if (rd_cnt() !== 0) begin
      failures++; $display("FAIL basic_no_reads got=%0d exp=0", rd_cnt()); end
`endif
  endtask

  task automatic test_delay();
    bit to;
    int k;
    int gap;
    load_basic(); clear_log();
    lut_mem[1] = {8'hFE, 16'h0000, 8'd5};
    pulse_start();
    wait_end(to);
    checks++; if (to || done !== 1'b1) begin
      failures++; $display("FAIL delay_done to=%b done=%b exp done=1", to, done); end
    checks++; if (wr_cnt(-1) !== 2 || wr_cnt(1) !== 0) begin
      failures++; $display("FAIL delay_wr_count got=%0d/%0d exp=2/0", wr_cnt(-1), wr_cnt(1)); end
    k = -1;
    for (int i = 0; i < acc_cnt; i++) if (k < 0 && acc_idx[i] == 2) k = i;
    // 5 ms * 10 ticks = 50, plus 7 fixed cycles of NEXT/FETCH/DECODE/exit
    gap = (k > 0) ? (acc_cyc[k] - 1) - done_log[k-1] : -1;
    checks++; if (gap < 55 || gap > 59) begin
      failures++; $display("FAIL delay_gap got=%0d exp=57+-2", gap); end
  endtask

  task automatic test_retry();
    bit to;
    load_basic(); clear_log();
    nack_idx = 0; nack_times = 2;
    pulse_start();
    wait_end(to);
    nack_idx = -1;
    checks++; if (wr_cnt(0) !== 3 || wr_cnt(-1) !== 5) begin
      failures++; $display("FAIL retry_counts got=%0d/%0d exp=3/5", wr_cnt(0), wr_cnt(-1)); end
    checks++; if (to || {done, error} !== 2'b10) begin
      failures++; $display("FAIL retry_end done/err=%b exp=10", {done, error}); end
  endtask

  task automatic test_error_restart();
    bit to;
    load_basic(); clear_log();
    nack_idx = 2; nack_times = 99;
    pulse_start();
    wait_end(to);
    nack_idx = -1;
    checks++; if (wr_cnt(2) !== 4) begin
      failures++; $display("FAIL err_attempts got=%0d exp=4", wr_cnt(2)); end
    @(negedge clk);
    checks++; if (to || {done, error, busy} !== 3'b010 || err_index !== 4'd2) begin
      failures++; $display("FAIL err_flags done/err/busy=%b idx=%0d exp=010 idx=2",
                           {done, error, busy}, err_index); end
`ifdef CMOS_CFG_VERIFY_EN
    checks++; if (verify_fail !== 1'b0) begin
      failures++; $display("FAIL err_vfail got=%b exp=0", verify_fail); end
`endif
    clear_log();
    pulse_start();
    checks++; if ({error, err_index} !== 5'd0) begin
      failures++; $display("FAIL restart_clear err=%b idx=%0d exp=0/0", error, err_index); end
    wait_end(to);
    checks++; if (to || done !== 1'b1 || acc_idx[0] !== 0 || wr_cnt(-1) !== 3) begin
      failures++; $display("FAIL restart_walk done=%b first=%0d writes=%0d exp=1/0/3",
                           done, acc_idx[0], wr_cnt(-1)); end
  endtask

  task automatic test_start_busy();
    bit to;
    load_basic(); clear_log();
    pulse_start();
    repeat (6) @(negedge clk);
    pulse_start();
    wait_end(to);
    checks++; if (to || wr_cnt(-1) !== 3 || wr_cnt(0) !== 1) begin
      failures++; $display("FAIL busy_start writes=%0d idx0=%0d exp=3/1", wr_cnt(-1), wr_cnt(0)); end
  endtask

  task automatic test_depth_limit();
    bit to;
    clear_log();
    for (int i = 0; i < 16; i++) lut_mem[i] = {8'h30, 16'(i), 8'(i + 1)};
    pulse_start();
    wait_end(to);
    checks++; if (to || done !== 1'b1 || lut_index !== 4'd7 || wr_cnt(-1) !== 8) begin
      failures++; $display("FAIL depth_limit done=%b idx=%0d writes=%0d exp=1/7/8",
                           done, lut_index, wr_cnt(-1)); end
  endtask

  task automatic test_ready_stall();
    int n;
    bit stable;
    logic [32:0] snap;
    load_basic(); clear_log();
    ifc.i2c_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!ifc.i2c_req && n < 20) begin @(negedge clk); n++; end
    snap = {ifc.i2c_req, ifc.i2c_dev_addr, ifc.i2c_reg_addr, ifc.i2c_wdata};
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({ifc.i2c_req, ifc.i2c_dev_addr, ifc.i2c_reg_addr, ifc.i2c_wdata} !== snap) stable = 1'b0;
    end
    checks++; if (!stable || snap !== {1'b1, lut_mem[0]}) begin
      failures++; $display("FAIL stall_stable stable=%b snap=%h exp=1/1%h", stable, snap, lut_mem[0]); end
    ifc.i2c_ready = 1'b1;
    @(negedge clk);
    checks++; if (acc_cnt !== 1 || ifc.i2c_req !== 1'b0) begin
      failures++; $display("FAIL stall_accept acc=%0d req=%b exp=1/0", acc_cnt, ifc.i2c_req); end
    // hold the next request pending, then reset underneath it
    ifc.i2c_ready = 1'b0;
    n = 0;
    while (!ifc.i2c_req && n < 30) begin @(negedge clk); n++; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ifc.i2c_req !== 1'b0 || busy !== 1'b0 || lut_index !== 4'd0) begin
      failures++; $display("FAIL async_reset req=%b busy=%b idx=%0d exp=0/0/0", ifc.i2c_req, busy, lut_index); end
    @(negedge clk);
    rst_n = 1'b1;
    ifc.i2c_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || ifc.i2c_req !== 1'b0) begin
      failures++; $display("FAIL reset_no_autostart busy=%b req=%b exp=0/0", busy, ifc.i2c_req); end
  endtask

`ifdef CMOS_CFG_VERIFY_EN
  task automatic test_verify();
    bit to;
    bit order_ok;
    for (int i = 0; i < 16; i++) lut_mem[i] = {8'hFF, 16'h0000, 8'h00};
    lut_mem[0] = {8'h42, 16'h0010, 8'h55};
    clear_log();
    rd_corrupt = 1'b1;
    pulse_start();
    wait_end(to);
    rd_corrupt = 1'b0;
    order_ok = (acc_cnt == 8);
    for (int i = 0; i < acc_cnt; i++)
      if (acc_rw[i] !== 1'(i % 2) || acc_dev[i] !== 8'h42 || acc_reg[i] !== 16'h0010) order_ok = 1'b0;
    checks++; if (!order_ok) begin
      failures++; $display("FAIL verify_pairs acc=%0d exp=8 alternating w/r", acc_cnt); end
    @(negedge clk);
    checks++; if (to || {error, verify_fail, done} !== 3'b110) begin
      failures++; $display("FAIL verify_flags err/vf/done=%b exp=110", {error, verify_fail, done}); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) lut_mem[i] = 32'hFF000000;
    ifc.i2c_ready = 1'b1;
    test_reset();
    test_basic();
    test_delay();
    test_retry();
    test_error_restart();
    test_start_busy();
    test_depth_limit();
    test_ready_stall();
`ifdef CMOS_CFG_VERIFY_EN
    test_verify();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
